surv_ring_mem: RTL and testbench
================================

Name: surv_ring_mem

Overview:
- Parametrised survivor-history memory for the Viterbi traceback path: WIDTH-bit words, DEPTH entries, organised as a circular history buffer.
- Writes append at an internal write pointer; reads are addressed relative to the newest entry (distance back).
- Read and write ports are independent, so the add-compare-select unit can store a new survivor word in the same cycle the traceback unit reads an older one.
- Sits between the ACS array (writer) and the traceback FSM (reader).

Parameters:
- WIDTH, 8, data word width in bits (one survivor bit per state).
- DEPTH, 1024, number of entries; any value >= 2; need not be a power of two.
- AW, $clog2(DEPTH), address and distance width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous history clear; empties the buffer, memory contents untouched.
- wr_en  in  1  append wr_data at the write pointer this cycle.
- wr_data  in  WIDTH  word to append.
- rd_req  in  1  request a read this cycle.
- rd_back  in  AW  distance back from the newest entry; 0 = most recently written.
- rd_valid  out  1  one-cycle pulse, one cycle after rd_req.
- rd_data  out  WIDTH  read result; holds its last value when rd_valid is 0.
- rd_err  out  1  pulses with rd_valid when the request exceeded the stored history.
- count  out  AW+1  number of valid entries, 0..DEPTH.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Internal state: wr_ptr=0, count=0.
  - Outputs: rd_valid=0, rd_err=0, rd_data=0, full=0.
  - Memory array is not reset.
- Write (wr_en=1):
  - mem[wr_ptr] <= wr_data.
  - wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1, with explicit wrap (no reliance on power-of-two overflow).
  - count <= min(count+1, DEPTH).
  - When full, the write overwrites the oldest entry and count stays at DEPTH.
- Read (rd_req=1):
  - Address = (wr_ptr - 1 - rd_back) mod DEPTH, computed from the pre-edge wr_ptr.
  - rd_valid=1 on the next cycle; latency is exactly 1.
  - If rd_back >= count (pre-edge value): rd_err=1, rd_data=0, and the array is not consulted for the result.
  - Otherwise: rd_err=0, rd_data = stored word.
- Simultaneous read and write:
  - The read sees the pre-write state; a word written in cycle N is readable with rd_back=0 by a request in cycle N+1 or later.
  - Full buffer with rd_back=DEPTH-1 targets the slot being overwritten in the same cycle: read-before-write, returns the old word.
- clr:
  - wr_ptr <= 0, count <= 0.
  - clr with wr_en in the same cycle: the clear applies first, then the write lands at slot 0; result is wr_ptr=1, count=1.
  - A read in the clr cycle uses the pre-clear state (valid data, not an error).
- rd_back arithmetic is done in AW+1 bits to avoid underflow aliasing when DEPTH is not a power of two.
- No back-pressure: every rd_req produces exactly one rd_valid. Back-to-back reads every cycle are supported.
- rst_n asserted mid-operation aborts any in-flight read; rd_valid for that read is not produced.

Decomposition:
- Package viterbi_pkg: default WIDTH/DEPTH constants for the decoder configuration (number of states, traceback depth).
- Sub-module sdp_ram_core:
  - Simple dual-port storage: one write port, one registered read port, read-before-write.
  - No reset on the array.
- surv_ring_mem holds the pointer, count, error detection and output registers.

Test Plan:
- Reset, then 3 writes of 0x11, 0x22, 0x33 -> count=3. Reads with rd_back=0,1,2 on consecutive cycles -> rd_data 0x33, 0x22, 0x11, each one cycle after its request, rd_err=0.
- After the above, read rd_back=3 -> rd_valid=1, rd_err=1, rd_data=0.
- DEPTH=5: write 0..6 (7 words) -> full=1, count=5. rd_back=0 -> 6; rd_back=4 -> 2 (wrap and oldest overwritten).
- DEPTH=5 full: write 0xAA while reading rd_back=4 in the same cycle -> returns the old oldest word (2). Next cycle rd_back=0 -> 0xAA.
- With count=4: assert clr together with wr_en and data 0x5A -> next cycle count=1. rd_back=0 -> 0x5A; rd_back=1 -> rd_err=1.
- Pull rst_n low between rd_req and its response -> rd_valid stays 0, count=0, rd_data=0 immediately (asynchronous).

Source files
------------

// File: rtl/viterbi_pkg.sv
// Decoder-wide configuration defaults shared by the Viterbi datapath blocks.
package viterbi_pkg;

    localparam int unsigned NumStates = 8;     // trellis states, one survivor bit each
    localparam int unsigned TbDepth   = 1024;  // traceback history length

endpackage

// File: rtl/sdp_ram_core.sv
// Simple dual-port storage: one write port, one registered read-before-write read port.
module sdp_ram_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem[rd_addr_i];
        end
    end

    // Both updates are non-blocking, so a same-address read returns the old word.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/surv_ring_mem.sv
// Circular survivor-history buffer: appends at a write pointer, reads by distance from newest.
module surv_ring_mem
    import viterbi_pkg::*;
#(
    parameter int WIDTH = NumStates,
    parameter int DEPTH = TbDepth,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_back,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_err,
    output logic [AW:0]      count,
    output logic             full
);

    localparam int            CW      = AW + 1;
    localparam logic [AW:0]   DepthW  = CW'(DEPTH);
    localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;
    logic             rd_zero_q, rd_zero_d;

    logic [AW-1:0]    base_ptr;
    logic [AW:0]      base_cnt;
    logic             rd_hit;
    logic [AW:0]      rd_addr_raw;
    logic [AW:0]      rd_addr_ext;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] ram_rdata;

    always_comb begin
        rd_hit = {1'b0, rd_back} < count_q;
        // Offset by DEPTH so the subtraction never goes negative for in-range distances.
        rd_addr_raw = {1'b0, wr_ptr_q} + (DepthW - CW'(1)) - {1'b0, rd_back};
        rd_addr_ext = (rd_addr_raw >= DepthW) ? (rd_addr_raw - DepthW) : rd_addr_raw;
        rd_addr     = rd_addr_ext[AW-1:0];

        base_ptr = clr ? '0 : wr_ptr_q;
        base_cnt = clr ? '0 : count_q;
        wr_ptr_d = base_ptr;
        count_d  = base_cnt;
        if (wr_en) begin
            wr_ptr_d = (base_ptr == LastPtr) ? '0 : base_ptr + AW'(1);
            count_d  = (base_cnt == DepthW) ? base_cnt : base_cnt + CW'(1);
        end

        rd_valid_d = rd_req;
        rd_err_d   = rd_req & ~rd_hit;
        // Error results read as zero and keep doing so until the next good read.
        rd_zero_d  = rd_req ? ~rd_hit : rd_zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    sdp_ram_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (base_ptr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_req & rd_hit),
        .rd_addr_i (rd_addr),
        .rd_data_o (ram_rdata)
    );

    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign rd_data  = rd_zero_q ? '0 : ram_rdata;
    assign count    = count_q;
    assign full     = (count_q == DepthW);

endmodule

// File: tb/tb_surv_ring_mem.sv
// Bench for surv_ring_mem: directed cases plus random traffic against a queue-based history model.
module tb_surv_ring_mem;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_req = 1'b0;
    logic [AW-1:0]    rd_back = '0;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_err;
    logic [AW:0]      count;
    logic             full;

    int n_checks = 0;
    int n_errors = 0;

    // Model: history queue, newest at the back; plus the word rd_data should be showing.
    logic [WIDTH-1:0] hist [$];
    logic [WIDTH-1:0] exp_data = '0;

    surv_ring_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_back  (rd_back),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .count    (count),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, predict from pre-edge history, update model, check after edge.
    task automatic step(input logic c, input logic w, input logic [WIDTH-1:0] d,
                        input logic r, input logic [AW-1:0] b);
        logic exp_err;
        int   idx;
        clr = c; wr_en = w; wr_data = d; rd_req = r; rd_back = b;
        exp_err = 1'b0;
        if (r) begin
            if (int'(b) >= hist.size()) begin
                exp_err  = 1'b1;
                exp_data = '0;
            end else begin
                idx      = hist.size() - 1 - int'(b);
                exp_data = hist[idx];
            end
        end
        if (c) hist.delete();
        if (w) begin
            hist.push_back(d);
            if (hist.size() > DEPTH) void'(hist.pop_front());
        end
        @(posedge clk);
        #1;
        check("rd_valid", 32'(rd_valid), 32'(r));
        check("rd_err", 32'(rd_err), 32'(exp_err));
        check("rd_data", 32'(rd_data), 32'(exp_data));
        check("count", 32'(count), 32'(hist.size()));
        check("full", 32'(full), 32'(hist.size() == DEPTH));
        clr = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three writes then reads at distance 0..3
        step(0, 1, 8'h11, 0, 0);
        step(0, 1, 8'h22, 0, 0);
        step(0, 1, 8'h33, 0, 0);
        check("cnt3", 32'(count), 32'd3);
        step(0, 0, 8'h00, 1, 0);
        check("back0", 32'(rd_data), 32'h33);
        step(0, 0, 8'h00, 1, 1);
        check("back1", 32'(rd_data), 32'h22);
        step(0, 0, 8'h00, 1, 2);
        check("back2", 32'(rd_data), 32'h11);
        step(0, 0, 8'h00, 1, 3);
        check("back3_err", 32'(rd_err), 32'd1);
        check("back3_data", 32'(rd_data), 32'd0);
        step(0, 0, 8'h00, 0, 0);

        // Wrap: seven words into five slots
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 8'(i), 0, 0);
        check("wrap_full", 32'(full), 32'd1);
        check("wrap_cnt", 32'(count), 32'd5);
        step(0, 0, 8'h00, 1, 0);
        check("wrap_newest", 32'(rd_data), 32'd6);
        step(0, 0, 8'h00, 1, 4);
        check("wrap_oldest", 32'(rd_data), 32'd2);

        // Read-before-write on the slot being overwritten
        step(0, 1, 8'hAA, 1, 4);
        check("rbw_old", 32'(rd_data), 32'd2);
        step(0, 0, 8'h00, 1, 0);
        check("rbw_new", 32'(rd_data), 32'hAA);

        // clr together with a write, read in the clr cycle sees old history
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
        step(1, 1, 8'h5A, 1, 3);
        check("clr_rd_old", 32'(rd_data), 32'h40);
        check("clr_cnt", 32'(count), 32'd1);
        step(0, 0, 8'h00, 1, 0);
        check("clr_back0", 32'(rd_data), 32'h5A);
        step(0, 0, 8'h00, 1, 1);
        check("clr_back1_err", 32'(rd_err), 32'd1);

        // Asynchronous reset between a request and its response
        step(0, 1, 8'h77, 0, 0);
        rd_req = 1'b1; rd_back = '0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_rd_data", 32'(rd_data), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        @(posedge clk);
        #1;
        check("arst_rd_valid", 32'(rd_valid), 32'd0);
        rd_req = 1'b0;
        hist.delete();
        exp_data = '0;
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom), 1'($urandom),
                 AW'($urandom_range(0, (1 << AW) - 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
